// File: rtl/orc_pkg.sv
// Shared types and defaults for the out-of-order reorder collector.
package orc_pkg;
    localparam int ID_W_DEF   = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ID_IDLE    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } orc_state_e;
endpackage

// File: rtl/ooo_reorder_collector_if.sv
// Request/response and in-order release stream between responder, collector and consumer.
interface ooo_reorder_collector_if
    import orc_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_vld;
    logic              rsp_vld;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              out_vld;
    logic              out_rdy;
    logic [ID_W-1:0]   out_id;
    logic [DATA_W-1:0] out_data;

    modport master (
        output req_vld,
        input  rsp_vld, rsp_id, rsp_data,
        output out_vld, out_id, out_data,
        input  out_rdy
    );

    modport slave (
        input  req_vld,
        output rsp_vld, rsp_id, rsp_data,
        input  out_vld, out_id, out_data,
        output out_rdy
    );
endinterface

// File: rtl/orc_slot_store.sv
// Payload array plus valid bitmap indexed by ID 1..NUM_ID; one capture port, one release port.
module orc_slot_store
    import orc_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_ID = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_all,
    input  logic              wr_en,
    input  logic [ID_W-1:0]   wr_id,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_hit,
    input  logic [ID_W-1:0]   rd_id,
    input  logic              rd_clr,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data
);
    logic [NUM_ID:1]   vld_q;
    logic [DATA_W-1:0] mem_q [1:NUM_ID];

    function automatic logic in_range(input logic [ID_W-1:0] id);
        return (int'(id) >= 1) && (int'(id) <= NUM_ID);
    endfunction

    assign wr_hit  = in_range(wr_id) && vld_q[wr_id];
    assign rd_vld  = in_range(rd_id) && vld_q[rd_id];
    assign rd_data = in_range(rd_id) ? mem_q[rd_id] : '0;

    // Capture and release never target the same ID in one cycle: the top drops
    // a capture whose slot is still valid.
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            vld_q <= '0;
        end else begin
            if (wr_en && in_range(wr_id)) vld_q[wr_id] <= 1'b1;
            if (rd_clr && in_range(rd_id)) vld_q[rd_id] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_id)) mem_q[wr_id] <= wr_data;
    end
endmodule

// File: rtl/ooo_reorder_collector.sv
// Issues requests, captures tagged responses in any order, releases them in ascending ID order.
// Optional idle watchdog is built only when ORC_TIMEOUT_EN is defined.
module ooo_reorder_collector
    import orc_pkg::*;
#(
    parameter int ID_W            = ID_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int NUM_ID          = 10,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYC     = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    ooo_reorder_collector_if.master bus,
    output logic done,
    output logic dup_err,
    output logic range_err,
    output logic timeout_err
);
    // state    | meaning
    // ST_IDLE  | after reset, waiting for start
    // ST_RUN   | issuing requests, capturing and releasing
    // ST_DRAIN | all requests issued, releasing remaining IDs
    // ST_DONE  | run finished (or watchdog fired), waiting for start
    localparam int CNT_W = $clog2(NUM_ID + 1);

    orc_state_e        state_q, state_nxt;
    logic [CNT_W-1:0]  issued_q, released_q, outstanding_q;
    logic [CNT_W-1:0]  issued_nxt, released_nxt, outstanding_nxt;
    logic [ID_W-1:0]   exp_id_q;
    logic              req_vld_q, req_nxt;
    logic              done_q, dup_q, range_q;
    logic              active, start_ok, fire, rsp_legal, cap_en, cap_hit, wd_fire;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;

    assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_ok  = start && !active;
    assign rsp_legal = (int'(bus.rsp_id) != ID_IDLE) && (int'(bus.rsp_id) <= NUM_ID);
    assign cap_en    = active && bus.rsp_vld && rsp_legal && !cap_hit;

    assign bus.out_vld  = active && rd_vld;
    assign bus.out_id   = bus.out_vld ? exp_id_q : '0;
    assign bus.out_data = bus.out_vld ? rd_data : '0;
    assign bus.req_vld  = req_vld_q;
    assign fire         = bus.out_vld && bus.out_rdy;

    assign done      = done_q;
    assign dup_err   = dup_q;
    assign range_err = range_q;

    orc_slot_store #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .NUM_ID (NUM_ID)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .clr_all (start_ok || wd_fire),
        .wr_en   (cap_en),
        .wr_id   (bus.rsp_id),
        .wr_data (bus.rsp_data),
        .wr_hit  (cap_hit),
        .rd_id   (exp_id_q),
        .rd_clr  (fire),
        .rd_vld  (rd_vld),
        .rd_data (rd_data)
    );

    always_comb begin
        issued_nxt      = issued_q + CNT_W'(req_vld_q);
        released_nxt    = released_q + CNT_W'(fire);
        outstanding_nxt = outstanding_q;
        if (req_vld_q && !fire)
            outstanding_nxt = outstanding_q + CNT_W'(1);
        else if (!req_vld_q && fire && (outstanding_q != '0))
            outstanding_nxt = outstanding_q - CNT_W'(1);

        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
            default: begin
                if (wd_fire || (int'(released_nxt) == NUM_ID))
                    state_nxt = ST_DONE;
                else if ((state_q == ST_RUN) && (int'(issued_nxt) == NUM_ID))
                    state_nxt = ST_DRAIN;
            end
        endcase

        // Looking at next-cycle counts keeps the registered req_vld inside the credit limit.
        req_nxt = 1'b0;
        if (start_ok)
            req_nxt = 1'b1;
        else if (state_nxt == ST_RUN)
            req_nxt = (int'(outstanding_nxt) < MAX_OUTSTANDING) && (int'(issued_nxt) < NUM_ID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_vld_q     <= 1'b0;
            issued_q      <= '0;
            released_q    <= '0;
            outstanding_q <= '0;
            exp_id_q      <= ID_W'(1);
            done_q        <= 1'b0;
            dup_q         <= 1'b0;
            range_q       <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            req_vld_q <= req_nxt;
            if (start_ok) begin
                issued_q      <= '0;
                released_q    <= '0;
                outstanding_q <= '0;
                exp_id_q      <= ID_W'(1);
                done_q        <= 1'b0;
                dup_q         <= 1'b0;
                range_q       <= 1'b0;
            end else begin
                issued_q      <= issued_nxt;
                released_q    <= released_nxt;
                outstanding_q <= outstanding_nxt;
                if (fire) exp_id_q <= exp_id_q + ID_W'(1);
                if (active && bus.rsp_vld && !rsp_legal) range_q <= 1'b1;
                if (active && bus.rsp_vld && rsp_legal && cap_hit) dup_q <= 1'b1;
                if (active && (state_nxt == ST_DONE)) done_q <= 1'b1;
            end
        end
    end

`ifdef ORC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            tmo_q;

    // Down-counter of idle cycles; terminal count 1 marks the TIMEOUT_CYC-th idle cycle.
    assign wd_fire     = active && !bus.rsp_vld && !fire && (wd_q == WD_W'(1));
    assign timeout_err = tmo_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok || !active || bus.rsp_vld || fire)
            wd_q <= WD_W'(TIMEOUT_CYC);
        else if (wd_q != '0)
            wd_q <= wd_q - WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            tmo_q <= 1'b0;
        else if (wd_fire)
            tmo_q <= 1'b1;
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_ooo_reorder_collector.sv
// Directed bench for ooo_reorder_collector: ordering, reverse fill, errors, credits, reset, watchdog.
module tb_ooo_reorder_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic done_a, dup_a, range_a, tmo_a;
    logic done_b, dup_b, range_b, tmo_b;
    int   total = 0;
    int   bad   = 0;

    ooo_reorder_collector_if #(.ID_W(4), .DATA_W(8)) ifa ();
    ooo_reorder_collector_if #(.ID_W(4), .DATA_W(8)) ifb ();

    ooo_reorder_collector #(.ID_W(4), .DATA_W(8), .NUM_ID(10), .MAX_OUTSTANDING(4), .TIMEOUT_CYC(64)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
        .done(done_a), .dup_err(dup_a), .range_err(range_a), .timeout_err(tmo_a)
    );

    ooo_reorder_collector #(.ID_W(4), .DATA_W(8), .NUM_ID(10), .MAX_OUTSTANDING(10), .TIMEOUT_CYC(64)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
        .done(done_b), .dup_err(dup_b), .range_err(range_b), .timeout_err(tmo_b)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    function automatic logic [7:0] pay(input int id);
        return 8'(id * 17 + 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic send_a(input int id, input logic [7:0] d);
        ifa.rsp_vld  = 1'b1;
        ifa.rsp_id   = 4'(id);
        ifa.rsp_data = d;
    endtask

    // Responder model on DUT A: each req_vld cycle makes the next ID pending;
    // one pending ID answered per cycle (lowest first in mode 0, random otherwise).
    task automatic run_flow(input int mode, input int rdy_pct, input int stop_n,
                            input string tag, output int span);
        int pool[$];
        int issued, released, first_c, last_c, pick, id;
        issued = 0; released = 0; first_c = -1; last_c = -1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int cyc = 0; cyc < 400 && released < stop_n; cyc++) begin
            ifa.rsp_vld = 1'b0;
            if (pool.size() > 0) begin
                pick = (mode == 0) ? 0 : int'($urandom_range(pool.size() - 1));
                id = pool[pick];
                pool.delete(pick);
                send_a(id, pay(id));
            end
            ifa.out_rdy = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (ifa.req_vld) begin
                issued++;
                pool.push_back(issued);
            end
            if (ifa.out_vld && ifa.out_rdy) begin
                released++;
                chk({tag, "_id"}, 32'(ifa.out_id), 32'(released));
                chk({tag, "_data"}, 32'(ifa.out_data), 32'(pay(released)));
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            tick();
        end
        ifa.rsp_vld = 1'b0;
        chk({tag, "_count"}, 32'(released), 32'(stop_n));
        span = last_c - first_c;
    endtask

    initial begin
        int span, nreq;
        ifa.rsp_vld = 1'b0; ifa.rsp_id = '0; ifa.rsp_data = '0; ifa.out_rdy = 1'b0;
        ifb.rsp_vld = 1'b0; ifb.rsp_id = '0; ifb.rsp_data = '0; ifb.out_rdy = 1'b1;

        // reset state
        tick(); tick();
        chk("rst_req", 32'(ifa.req_vld), 0);
        chk("rst_out_vld", 32'(ifa.out_vld), 0);
        chk("rst_out_id", 32'(ifa.out_id), 0);
        chk("rst_done", 32'(done_a), 0);
        rst = 1'b0;
        tick();
        chk("idle_req", 32'(ifa.req_vld), 0);
        chk("idle_errs", 32'({dup_a, range_a, tmo_a}), 0);

        // 1: in-order responses, always ready
        run_flow(0, 100, 10, "t1", span);
        chk("t1_back_to_back", 32'(span), 9);
        chk("t1_done", 32'(done_a), 1);
        chk("t1_errs", 32'({dup_a, range_a, tmo_a}), 0);

        // 2: reverse fill with 10 credits
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        nreq = 0;
        for (int i = 0; i < 30 && nreq < 10; i++) begin
            if (ifb.req_vld) nreq++;
            tick();
        end
        chk("t2_reqs", 32'(nreq), 10);
        chk("t2_req_off", 32'(ifb.req_vld), 0);
        for (int id = 10; id >= 1; id--) begin
            ifb.rsp_vld = 1'b1; ifb.rsp_id = 4'(id); ifb.rsp_data = pay(id);
            tick();
            if (id > 1) chk("t2_hold", 32'(ifb.out_vld), 0);
        end
        ifb.rsp_vld = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("t2_vld", 32'(ifb.out_vld), 1);
            chk("t2_id", 32'(ifb.out_id), 32'(k));
            chk("t2_data", 32'(ifb.out_data), 32'(pay(k)));
            tick();
        end
        chk("t2_done", 32'(done_b), 1);

        // 3: shuffled responses, 50% ready
        run_flow(1, 50, 10, "t3", span);
        chk("t3_done", 32'(done_a), 1);
        chk("t3_errs", 32'({dup_a, range_a, tmo_a}), 0);

        // 4: duplicate and out-of-range IDs
        ifa.out_rdy = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t4_clr_done", 32'(done_a), 0);
        send_a(3, pay(3));
        tick();
        chk("t4_dup_first", 32'(dup_a), 0);
        send_a(3, ~pay(3));
        tick();
        chk("t4_dup", 32'(dup_a), 1);
        chk("t4_no_range", 32'(range_a), 0);
        send_a(11, 8'h5a);
        tick();
        chk("t4_range_11", 32'(range_a), 1);
        send_a(2, pay(2));
        tick();
        send_a(1, pay(1));
        tick();
        ifa.rsp_vld = 1'b0;
        chk("t4_vld1", 32'(ifa.out_vld), 1);
        chk("t4_id1", 32'(ifa.out_id), 1);
        tick();
        chk("t4_stall_id", 32'(ifa.out_id), 1);
        chk("t4_stall_data", 32'(ifa.out_data), 32'(pay(1)));
        ifa.out_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk("t4_rel_id", 32'(ifa.out_id), 32'(k));
            chk("t4_rel_data", 32'(ifa.out_data), 32'(pay(k)));
            tick();
        end
        chk("t4_gap", 32'(ifa.out_vld), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_errs", 32'({dup_a, range_a}), 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_a(0, 8'h11);
        tick();
        ifa.rsp_vld = 1'b0;
        chk("t4_range_0", 32'(range_a), 1);
        chk("t4_range_0_nodup", 32'(dup_a), 0);

        // 5: credit limit with responses withheld
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.out_rdy = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            if (ifa.req_vld) nreq++;
            tick();
        end
        chk("t5_reqs", 32'(nreq), 4);
        chk("t5_req_off", 32'(ifa.req_vld), 0);

        // 6: reset after five releases, then a clean rerun
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_flow(0, 100, 5, "t6a", span);
        rst = 1'b1;
        tick();
        chk("t6_req", 32'(ifa.req_vld), 0);
        chk("t6_out", 32'({ifa.out_vld, ifa.out_id, ifa.out_data}), 0);
        chk("t6_flags", 32'({done_a, dup_a, range_a, tmo_a}), 0);
        rst = 1'b0;
        run_flow(0, 100, 10, "t6b", span);
        chk("t6_done", 32'(done_a), 1);
        chk("t6_errs", 32'({dup_a, range_a, tmo_a}), 0);

`ifdef ORC_TIMEOUT_EN
        // 7: responses stop after ID 5; watchdog ends the run 64 idle cycles later
        ifa.out_rdy = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int id = 1; id <= 5; id++) begin
            send_a(id, pay(id));
            tick();
        end
        ifa.rsp_vld = 1'b0;
        for (int n = 0; n < 64; n++) tick();
        chk("t7_not_yet", 32'({done_a, tmo_a}), 0);
        tick();
        chk("t7_done", 32'(done_a), 1);
        chk("t7_timeout", 32'(tmo_a), 1);
        chk("t7_discard", 32'(ifa.out_vld), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
